// File: rtl/onchip_mem_tester_pkg.sv
// Shared types and constants for the on-chip RAM tester.
//   state_t   : tester FSM states
//   LFSR_MASK : Galois feedback mask of the optional LFSR pattern
//   ERR_SAT   : saturation value of the mismatch counter
//   lfsr_adv  : one Galois LFSR step (right shift, feedback from bit 0)
package onchip_mem_tester_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int unsigned ERR_W     = 16;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [15:0] ERR_SAT   = 16'hFFFF;

  function automatic logic [31:0] lfsr_adv(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/memtest_pattern_gen.sv
// Test-pattern source shared by the write phase and the read-expected path.
// Build option: MEMTEST_LFSR_EN selects a 32-bit Galois LFSR sequence;
// otherwise the pattern is SEED + address.
// Ports:
//   clk, reset : clock, async active-high reset
//   load       : an access is being set up and it is the first of its phase
//   step       : an access is being set up and it is not the first
//   addr       : word address of the access being set up
//   pattern    : data word for that access (combinational)
module memtest_pattern_gen
  import onchip_mem_tester_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter logic [31:0] SEED   = 32'hA5A5_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] pattern
);

`ifdef MEMTEST_LFSR_EN
  // A zero seed would lock the LFSR at zero.
  localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0] r_lfsr;
  logic [31:0] w_lfsr_nxt;
  logic        w_unused;

  // r_lfsr holds the word of the access currently on the bus.
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if (load) begin
      w_lfsr_nxt = SEED_NZ;
    end else if (step) begin
      w_lfsr_nxt = lfsr_adv(r_lfsr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED_NZ;
    end else begin
      r_lfsr <= w_lfsr_nxt;
    end
  end

  assign pattern  = DATA_W'(w_lfsr_nxt);
  assign w_unused = ^addr;
`else
  logic w_unused;

  // Address is zero-extended before the 32-bit add.
  assign pattern  = DATA_W'(SEED + 32'(addr));
  assign w_unused = ^{clk, reset, load, step};
`endif

endmodule

// File: rtl/onchip_mem_tester.sv
// Avalon-MM master that fills the on-chip RAM with a pattern, reads it back
// and reports pass/fail, a saturating error count and the first failure.
// Build option: MEMTEST_LFSR_EN (LFSR pattern, see memtest_pattern_gen).
// Ports:
//   clk, reset          : clock, async active-high reset
//   start, abort        : start pulse (IDLE only), abort level (forces IDLE)
//   avm_*               : Avalon-MM master to the RAM slave (no waitrequest,
//                         fixed read latency RD_LATENCY)
//   busy, done, pass    : status; done is a 1-cycle completion pulse
//   err_count           : mismatches, saturating at 16'hFFFF
//   fail_addr/fail_data : address and readdata of the first mismatch
module onchip_mem_tester
  import onchip_mem_tester_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter logic [31:0] SEED       = 32'hA5A5_0001,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_W-1:0]     avm_address,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic                  avm_clken,
  input  logic [DATA_W-1:0]     avm_readdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [DATA_W-1:0]     fail_data
);

  localparam int unsigned      BE_W      = DATA_W / 8;
  localparam int unsigned      DRN_W     = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(RD_LATENCY - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DRN_W-1:0]     r_drain;

  // Next-cycle values of the registered bus/status outputs.
  logic                 w_cs_d;
  logic                 w_wr_d;
  logic [ADDR_W-1:0]    w_addr_d;
  logic                 w_busy_d;
  logic                 w_done_d;
  logic                 w_load;
  logic                 w_step;
  logic                 w_rd_issue;
  logic [DATA_W-1:0]    w_pattern;

  logic                 r_cs;
  logic                 r_wr;
  logic [ADDR_W-1:0]    r_addr;
  logic [BE_W-1:0]      r_be;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [ERR_W-1:0]     r_err;
  logic [ADDR_W-1:0]    r_fail_addr;
  logic [DATA_W-1:0]    r_fail_data;

  // Compare pipeline: stage 0 mirrors the access on the bus.
  logic [RD_LATENCY:0]  r_pv;
  logic [ADDR_W-1:0]    r_pa [RD_LATENCY+1];
  logic [DATA_W-1:0]    r_pe [RD_LATENCY+1];

  logic                 w_start_acc;
  logic                 w_mismatch;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = WRITE;
      WRITE:   if (r_addr == LAST_ADDR) w_state_nxt = READ;
      READ:    if (r_addr == LAST_ADDR) w_state_nxt = DRAIN;
      DRAIN:   if (r_drain == DRN_LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort) begin
      w_state_nxt = IDLE;
    end
  end

  // Output decode: the access for the next cycle follows the next state;
  // the address restarts at 0 on entry to each phase.
  always_comb begin
    w_cs_d   = 1'b0;
    w_wr_d   = 1'b0;
    w_addr_d = '0;
    w_load   = 1'b0;
    w_busy_d = (w_state_nxt != IDLE);
    w_done_d = (r_state == DONE) && !abort;
    case (w_state_nxt)
      WRITE: begin
        w_cs_d = 1'b1;
        w_wr_d = 1'b1;
        if (r_state == WRITE) begin
          w_addr_d = r_addr + ADDR_W'(1);
        end else begin
          w_load = 1'b1;
        end
      end
      READ: begin
        w_cs_d = 1'b1;
        if (r_state == READ) begin
          w_addr_d = r_addr + ADDR_W'(1);
        end else begin
          w_load = 1'b1;
        end
      end
      default: ;
    endcase
    w_step     = w_cs_d && !w_load;
    w_rd_issue = w_cs_d && !w_wr_d;
  end

  // DRAIN length counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drain <= '0;
    end else if ((r_state == DRAIN) && (w_state_nxt == DRAIN)) begin
      r_drain <= r_drain + DRN_W'(1);
    end else begin
      r_drain <= '0;
    end
  end

  memtest_pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_pattern (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .step    (w_step),
    .addr    (w_addr_d),
    .pattern (w_pattern)
  );

  // Bus and status output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_cs    <= w_cs_d;
      r_wr    <= w_wr_d;
      r_addr  <= w_addr_d;
      r_be    <= {BE_W{w_cs_d}};
      r_wdata <= w_wr_d ? w_pattern : '0;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  // Read address/expected word travel RD_LATENCY stages behind the bus;
  // abort drops everything still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pv <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        r_pa[i] <= '0;
        r_pe[i] <= '0;
      end
    end else begin
      if (abort) begin
        r_pv <= '0;
      end else begin
        r_pv <= {r_pv[RD_LATENCY-1:0], w_rd_issue};
      end
      r_pa[0] <= w_addr_d;
      r_pe[0] <= w_pattern;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        r_pa[i] <= r_pa[i-1];
        r_pe[i] <= r_pe[i-1];
      end
    end
  end

  assign w_start_acc = (r_state == IDLE) && (w_state_nxt == WRITE);
  assign w_mismatch  = r_pv[RD_LATENCY] && !abort &&
                       (avm_readdata != r_pe[RD_LATENCY]);

  // Result registers: cleared on an accepted start, kept across abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pass      <= 1'b0;
      r_err       <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else if (w_start_acc) begin
      r_pass      <= 1'b0;
      r_err       <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      if (w_mismatch) begin
        if (r_err == '0) begin
          r_fail_addr <= r_pa[RD_LATENCY];
          r_fail_data <= avm_readdata;
        end
        if (r_err != ERR_SAT) begin
          r_err <= r_err + ERR_W'(1);
        end
      end
      if ((r_state == DONE) && !abort) begin
        r_pass <= (r_err == '0);
      end
    end
  end

  assign avm_address    = r_addr;
  assign avm_byteenable = r_be;
  assign avm_chipselect = r_cs;
  assign avm_write      = r_wr;
  assign avm_writedata  = r_wdata;
  assign avm_clken      = 1'b1;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign fail_addr      = r_fail_addr;
  assign fail_data      = r_fail_data;

endmodule
